// File: rtl/lsq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsq_pkg
// Purpose : Shared encodings and payload record for the banked-dcache
//           load/store queue (lsq_mbank and lsq_wake_entry).
// Contents: op codes, access-size codes, payload struct.
// Revision: 1.0 - initial release
// ============================================================================
package lsq_pkg;

  // Operation codes. OP_NONE entries hold a slot but never wait on a bank.
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_AMO   = 3'd3;

  // Access size codes.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Payload field widths for tag and ROB index. These are the widths the
  // queue stores; the top-level TAG_BITS/ROB_BITS must not exceed them.
  localparam int LSQ_TAG_W = 6;
  localparam int LSQ_ROB_W = 6;

  typedef struct packed {
    logic [2:0]           op;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [1:0]           size;
    logic                 sext;
    logic [LSQ_TAG_W-1:0] tag;
    logic [LSQ_ROB_W-1:0] rob;
  } lsq_payload_t;

endpackage : lsq_pkg
`default_nettype wire

// File: rtl/lsq_wake_entry.sv
`default_nettype none
// ============================================================================
// Module  : lsq_wake_entry
// Purpose : Wakeup state of one LSQ slot: valid bit, per-bank pending bits
//           and the MSHR slot index each pending bank waits on.
// Ports   : clk, rst           - clock, synchronous active-high reset
//           clr                - discard this entry (flush)
//           push, is_nop       - write this slot this cycle; op is OP_NONE
//           bank_need/bank_hit - per-bank access and hit flags of the push
//           mshr_wr_idx        - per-bank MSHR slot allocated for the push
//           mshr_fin/_idx      - per-bank fill completion broadcast
//           pop                - slot issued this cycle
//           valid, ready       - slot occupied; occupied with nothing pending
// Revision: 1.0 - initial release
// ============================================================================
module lsq_wake_entry #(
  parameter int NUM_BANKS     = 2,
  parameter int MSHR_IDX_BITS = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               push,
  input  logic                               is_nop,
  input  logic [NUM_BANKS-1:0]               bank_need,
  input  logic [NUM_BANKS-1:0]               bank_hit,
  input  logic [NUM_BANKS*MSHR_IDX_BITS-1:0] mshr_wr_idx,
  input  logic [NUM_BANKS-1:0]               mshr_fin,
  input  logic [NUM_BANKS*MSHR_IDX_BITS-1:0] mshr_fin_idx,
  input  logic                               pop,
  output logic                               valid,
  output logic                               ready
);

  logic [NUM_BANKS-1:0]                    pend;
  logic [NUM_BANKS-1:0][MSHR_IDX_BITS-1:0] idx;
  logic [NUM_BANKS-1:0]                    push_pend;
  logic [NUM_BANKS-1:0]                    wake;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // A fill finishing on the very slot being allocated this cycle would be
    // missed by the stored-index compare, so treat it as already done.
    assign push_pend[b] = bank_need[b] && !bank_hit[b] && !is_nop &&
                          !(mshr_fin[b] &&
                            mshr_fin_idx[b*MSHR_IDX_BITS +: MSHR_IDX_BITS] ==
                            mshr_wr_idx[b*MSHR_IDX_BITS +: MSHR_IDX_BITS]);
    assign wake[b] = pend[b] && mshr_fin[b] &&
                     (idx[b] == mshr_fin_idx[b*MSHR_IDX_BITS +: MSHR_IDX_BITS]);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      pend  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      pend  <= push_pend;
    end else begin
      if (pop) begin
        valid <= 1'b0;
      end
      pend <= pend & ~wake;
    end
  end

  // Stored indices are only meaningful while the matching pend bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        idx[b] <= mshr_wr_idx[b*MSHR_IDX_BITS +: MSHR_IDX_BITS];
      end
    end
  end

  assign ready = valid && (pend == '0);

endmodule : lsq_wake_entry
`default_nettype wire

// File: rtl/lsq_mbank.sv
`default_nettype none
// ============================================================================
// Module  : lsq_mbank
// Purpose : In-order load/store queue for a banked dcache. Entries wait on
//           per-bank MSHR fills and issue from the head in allocation order.
// Ports   : clk, rst, flush     - clock, sync active-high reset, discard all
//           alloc/alloc_ready   - push request and backpressure
//           op_in..rob_in       - payload of the push
//           bank_need/bank_hit  - per-bank access/hit of the push
//           mshr_wr_idx         - per-bank MSHR slot for a missing push
//           mshr_fin/_idx       - per-bank fill completion broadcast
//           out_valid/out_ready - head issue handshake
//           op_out..rob_out     - head payload (don't-care when !out_valid)
//           full, empty, count  - occupancy
// Revision: 1.0 - initial release
// ============================================================================
module lsq_mbank
  import lsq_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int NUM_BANKS     = 2,
  parameter int MSHR_IDX_BITS = 3,
  parameter int TAG_BITS      = 6,
  parameter int ROB_BITS      = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               alloc,
  output logic                               alloc_ready,
  input  logic [2:0]                         op_in,
  input  logic [31:0]                        addr_in,
  input  logic [31:0]                        data_in,
  input  logic [1:0]                         size_in,
  input  logic                               sext_in,
  input  logic [TAG_BITS-1:0]                tag_in,
  input  logic [ROB_BITS-1:0]                rob_in,
  input  logic [NUM_BANKS-1:0]               bank_need,
  input  logic [NUM_BANKS-1:0]               bank_hit,
  input  logic [NUM_BANKS*MSHR_IDX_BITS-1:0] mshr_wr_idx,
  input  logic [NUM_BANKS-1:0]               mshr_fin,
  input  logic [NUM_BANKS*MSHR_IDX_BITS-1:0] mshr_fin_idx,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [2:0]                         op_out,
  output logic [31:0]                        addr_out,
  output logic [31:0]                        data_out,
  output logic [1:0]                         size_out,
  output logic                               sext_out,
  output logic [TAG_BITS-1:0]                tag_out,
  output logic [ROB_BITS-1:0]                rob_out,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  lsq_payload_t     mem [DEPTH];
  lsq_payload_t     pl_in;
  lsq_payload_t     pl_head;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_ready;
  logic             do_push;
  logic             do_pop;

  assign full        = (cnt == CNT_W'(DEPTH));
  assign empty       = (cnt == '0);
  assign count       = cnt;
  assign alloc_ready = !full;

  // Flush wins over any same-cycle push or pop.
  assign do_push = alloc && !full && !flush;
  assign do_pop  = out_valid && out_ready && !flush;

  assign out_valid = ent_ready[head];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    lsq_wake_entry #(
      .NUM_BANKS     (NUM_BANKS),
      .MSHR_IDX_BITS (MSHR_IDX_BITS)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .clr          (flush),
      .push         (do_push && (tail == PTR_W'(i))),
      .is_nop       (op_in == OP_NONE),
      .bank_need    (bank_need),
      .bank_hit     (bank_hit),
      .mshr_wr_idx  (mshr_wr_idx),
      .mshr_fin     (mshr_fin),
      .mshr_fin_idx (mshr_fin_idx),
      .pop          (do_pop && (head == PTR_W'(i))),
      .valid        (ent_valid[i]),
      .ready        (ent_ready[i])
    );
  end

  // Pointers and occupancy. Pointer arithmetic wraps because DEPTH is a
  // power of two; full/empty come from the count alone.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        tail <= tail + PTR_W'(1);
      end
      if (do_pop) begin
        head <= head + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign pl_in.op   = op_in;
  assign pl_in.addr = addr_in;
  assign pl_in.data = data_in;
  assign pl_in.size = size_in;
  assign pl_in.sext = sext_in;
  assign pl_in.tag  = LSQ_TAG_W'(tag_in);
  assign pl_in.rob  = LSQ_ROB_W'(rob_in);

  // Payload storage carries no reset; validity lives in the entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= pl_in;
    end
  end

  assign pl_head  = mem[head];
  assign op_out   = pl_head.op;
  assign addr_out = pl_head.addr;
  assign data_out = pl_head.data;
  assign size_out = pl_head.size;
  assign sext_out = pl_head.sext;
  assign tag_out  = TAG_BITS'(pl_head.tag);
  assign rob_out  = ROB_BITS'(pl_head.rob);

endmodule : lsq_mbank
`default_nettype wire

// File: tb/tb_lsq_mbank.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsq_mbank
// Purpose : Directed self-checking bench for lsq_mbank (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsq_mbank;

  logic        clk = 1'b0;
  logic        rst, flush, alloc, alloc_ready;
  logic [2:0]  op_in;
  logic [31:0] addr_in, data_in;
  logic [1:0]  size_in;
  logic        sext_in;
  logic [5:0]  tag_in, rob_in;
  logic [1:0]  bank_need, bank_hit, mshr_fin;
  logic [5:0]  mshr_wr_idx, mshr_fin_idx;
  logic        out_valid, out_ready;
  logic [2:0]  op_out;
  logic [31:0] addr_out, data_out;
  logic [1:0]  size_out;
  logic        sext_out;
  logic [5:0]  tag_out, rob_out;
  logic        full, empty;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsq_mbank dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc(alloc), .alloc_ready(alloc_ready),
    .op_in(op_in), .addr_in(addr_in), .data_in(data_in), .size_in(size_in),
    .sext_in(sext_in), .tag_in(tag_in), .rob_in(rob_in),
    .bank_need(bank_need), .bank_hit(bank_hit), .mshr_wr_idx(mshr_wr_idx),
    .mshr_fin(mshr_fin), .mshr_fin_idx(mshr_fin_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_out(op_out), .addr_out(addr_out), .data_out(data_out), .size_out(size_out),
    .sext_out(sext_out), .tag_out(tag_out), .rob_out(rob_out),
    .full(full), .empty(empty), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one alloc request for the next edge.
  task automatic set_alloc(input logic [5:0] rob, input logic [1:0] need,
                           input logic [1:0] hit, input logic [5:0] wr);
    alloc       = 1'b1;
    op_in       = 3'd1;
    addr_in     = 32'h1000 + 32'(rob);
    data_in     = 32'hA000 + 32'(rob);
    tag_in      = rob ^ 6'h2A;
    rob_in      = rob;
    bank_need   = need;
    bank_hit    = hit;
    mshr_wr_idx = wr;
  endtask

  task automatic idle_in();
    alloc = 1'b0; flush = 1'b0; mshr_fin = 2'b00; mshr_fin_idx = 6'd0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc = 1'b0; op_in = 3'd0; addr_in = '0;
    data_in = '0; size_in = 2'd2; sext_in = 1'b0; tag_in = '0; rob_in = '0;
    bank_need = '0; bank_hit = '0; mshr_wr_idx = '0; mshr_fin = '0;
    mshr_fin_idx = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    // Fill to full with hits, drop a 9th, drain in order
    for (int i = 0; i < 8; i++) begin
      set_alloc(6'(i), 2'b01, 2'b01, 6'd0);
      tick();
    end
    idle_in();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_aready", 32'(alloc_ready), 32'd0);
    set_alloc(6'd9, 2'b01, 2'b01, 6'd0);
    tick();
    idle_in();
    chk("drop_count", 32'(count), 32'd8);
    chk("drop_head", 32'(rob_out), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_oval", 32'(out_valid), 32'd1);
      chk("drain_rob", 32'(rob_out), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_oval0", 32'(out_valid), 32'd0);

    // Two-bank miss: even idx 3, odd idx 5
    set_alloc(6'd10, 2'b11, 2'b00, {3'd5, 3'd3});
    tick();
    idle_in();
    chk("miss2_oval", 32'(out_valid), 32'd0);
    chk("miss2_count", 32'(count), 32'd1);
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd3};
    tick();
    idle_in();
    chk("miss2_half", 32'(out_valid), 32'd0);
    mshr_fin = 2'b10; mshr_fin_idx = {3'd5, 3'd0};
    tick();
    idle_in();
    chk("miss2_wake", 32'(out_valid), 32'd1);
    chk("miss2_rob", 32'(rob_out), 32'd10);
    chk("miss2_addr", addr_out, 32'h100A);
    chk("miss2_tag", 32'(tag_out), 32'(6'd10 ^ 6'h2A));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("miss2_empty", 32'(empty), 32'd1);

    // Same-cycle fill bypass
    set_alloc(6'd11, 2'b01, 2'b00, {3'd0, 3'd2});
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd2};
    tick();
    idle_in();
    chk("bypass_oval", 32'(out_valid), 32'd1);
    chk("bypass_rob", 32'(rob_out), 32'd11);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fin on a different slot during push must not bypass
    set_alloc(6'd12, 2'b01, 2'b00, {3'd0, 3'd2});
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd1};
    tick();
    idle_in();
    chk("nobyp_oval", 32'(out_valid), 32'd0);
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd2};
    tick();
    idle_in();
    chk("nobyp_wake", 32'(out_valid), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // In-order blocking: rob 0 waits on idx 4, rob 1 hits
    set_alloc(6'd0, 2'b01, 2'b00, {3'd0, 3'd4});
    tick();
    set_alloc(6'd1, 2'b01, 2'b01, 6'd0);
    tick();
    idle_in();
    out_ready = 1'b1;
    chk("ord_block", 32'(out_valid), 32'd0);
    tick();
    chk("ord_block2", 32'(out_valid), 32'd0);
    chk("ord_count", 32'(count), 32'd2);
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd4};
    tick();
    idle_in();
    chk("ord_first_v", 32'(out_valid), 32'd1);
    chk("ord_first", 32'(rob_out), 32'd0);
    tick();
    chk("ord_second_v", 32'(out_valid), 32'd1);
    chk("ord_second", 32'(rob_out), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("ord_empty", 32'(empty), 32'd1);

    // One fin wakes three entries on bank0 idx 6
    for (int i = 0; i < 3; i++) begin
      set_alloc(6'(20 + i), 2'b01, 2'b00, {3'd0, 3'd6});
      tick();
    end
    idle_in();
    chk("multi_wait", 32'(out_valid), 32'd0);
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd6};
    tick();
    idle_in();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("multi_oval", 32'(out_valid), 32'd1);
      chk("multi_rob", 32'(rob_out), 32'(20 + i));
      tick();
    end
    out_ready = 1'b0;
    chk("multi_empty", 32'(empty), 32'd1);

    // Flush with 5 pending entries plus same-cycle alloc
    for (int i = 0; i < 5; i++) begin
      set_alloc(6'(30 + i), 2'b01, 2'b00, {3'd0, 3'd7});
      tick();
    end
    idle_in();
    chk("fl_pre_count", 32'(count), 32'd5);
    set_alloc(6'd35, 2'b01, 2'b01, 6'd0);
    flush = 1'b1;
    tick();
    idle_in();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_oval", 32'(out_valid), 32'd0);
    mshr_fin = 2'b01; mshr_fin_idx = {3'd0, 3'd7};
    tick();
    idle_in();
    chk("fl_late_count", 32'(count), 32'd0);
    chk("fl_late_oval", 32'(out_valid), 32'd0);

    // Queue restarts cleanly; simultaneous push and pop
    set_alloc(6'd40, 2'b01, 2'b01, 6'd0);
    tick();
    idle_in();
    chk("post_oval", 32'(out_valid), 32'd1);
    chk("post_rob", 32'(rob_out), 32'd40);
    set_alloc(6'd41, 2'b10, 2'b10, 6'd0);
    out_ready = 1'b1;
    tick();
    idle_in();
    out_ready = 1'b0;
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_rob", 32'(rob_out), 32'd41);
    chk("pp_oval", 32'(out_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_lsq_mbank
`default_nettype wire

// File: doc/lsq_mbank.md
Name: lsq_mbank

Overview:
- In-order load/store queue for the banked dcache. Each entry records the op payload and, per bank, whether it still waits on an MSHR fill (tag = MSHR slot index).
- Entries wake up from per-bank MSHR-finish broadcasts. The head entry is issued to the write-back/response stage once no bank is pending.
- Generalises the fixed 2-bank, 8-deep LSQ to NUM_BANKS banks and DEPTH entries.
- Adds a valid/ready output handshake, flush, occupancy count and alloc backpressure.

Parameters:
- DEPTH, 8, number of entries; power of two, >=2.
- NUM_BANKS, 2, cache banks (even/odd = 2).
- MSHR_IDX_BITS, 3, width of an MSHR slot index per bank.
- TAG_BITS, 6, OOO tag width.
- ROB_BITS, 6, ROB index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all entries
- alloc  in  1  allocate request
- alloc_ready  out  1  = !full
- op_in  in  3  operation (0 = none)
- addr_in  in  32  address
- data_in  in  32  store data
- size_in  in  2  access size
- sext_in  in  1  sign-extend
- tag_in  in  TAG_BITS  OOO tag
- rob_in  in  ROB_BITS  ROB index
- bank_need  in  NUM_BANKS  bank touched by this op
- bank_hit  in  NUM_BANKS  bank hit this cycle
- mshr_wr_idx  in  NUM_BANKS*MSHR_IDX_BITS  MSHR slot allocated per bank for a miss
- mshr_fin  in  NUM_BANKS  per-bank fill completion strobe
- mshr_fin_idx  in  NUM_BANKS*MSHR_IDX_BITS  completing slot per bank
- out_valid  out  1  head entry ready
- out_ready  in  1  consumer accepts head
- op_out, addr_out, data_out, size_out, sext_out, tag_out, rob_out  out  widths as inputs  head payload
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset: rst is synchronous, active-high. It clears head/tail pointers to 0, count 0, all entry valid and pending bits. After reset: empty=1, full=0, alloc_ready=1, out_valid=0.
- Storage: circular buffer. Payload only in flops; no payload reset needed.
- Payload outputs are don't-care while out_valid=0.
- Push: when alloc && !full, write the payload at tail and advance tail (mod DEPTH).
- alloc while full is dropped; no state change.
- Pending bit per bank b at push:
  - pend[b] = bank_need[b] && !bank_hit[b] && !(mshr_fin[b] && mshr_fin_idx[b] == mshr_wr_idx[b]).
  - The third term is the same-cycle fill bypass.
  - The entry also stores mshr_wr_idx[b].
- An op_in==0 entry is stored with all pend=0.
- Wakeup, every cycle, for every valid entry and bank b: if pend[b] && mshr_fin[b] && stored_idx[b] == mshr_fin_idx[b], clear pend[b] at the clock edge.
  - One fin may wake multiple entries.
  - Banks are independent; simultaneous fins on all banks are allowed.
- out_valid = head entry valid && all its pend bits clear (combinational from state, no extra latency).
  - Earliest issue is the cycle after the push or wakeup edge.
- Pop: when out_valid && out_ready, invalidate head and advance head.
  - out_ready with !out_valid has no effect.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is still rejected (full is evaluated pre-edge).
- Wrap-around: pointers are log2(DEPTH) bits; full/empty are derived from count only.
- Non-head entries may become ready early but issue strictly in order.
- Flush: highest priority after rst; same effect as reset on pointers, count, valid and pend. A same-cycle alloc or pop is ignored.
- Reset or flush mid-wait: later mshr_fin broadcasts for discarded entries have no effect.

Decomposition:
- Package lsq_pkg:
  - LSQ op encoding constants (OP_NONE=0, load/store codes).
  - Size encodings.
  - Payload struct typedef {op, addr, data, size, sext, tag, rob}.
- One natural sub-module: lsq_wake_entry. It holds one entry's valid, pend[NUM_BANKS] and stored indices, and performs the per-bank compare/clear. It is instantiated DEPTH times in a generate loop.
- Top level owns pointers, count and the payload array.

Test Plan:
- Reset then 8 allocs with op=1, bank_need=2'b01, bank_hit=2'b01 -> full=1 and count=8. A 9th alloc is dropped. With out_ready=1, 8 pops in order: rob_out 0..7, out_valid high each cycle.
- Alloc A, bank_need=2'b11, miss both, idx even=3, odd=5. Then mshr_fin even idx 3 -> out_valid stays 0. Next, mshr_fin odd idx 5 -> out_valid=1 the cycle after that edge.
- Same-cycle bypass: alloc miss with mshr_wr_idx=2 while mshr_fin=1, mshr_fin_idx=2 -> entry stored ready; out_valid=1 next cycle.
- In-order block: entry0 waits on idx 4, entry1 hits. out_valid=0 until fin idx 4; then rob 0 issues before rob 1.
- Multi-wake: 3 entries all waiting on bank0 idx 6 -> a single fin wakes all three; with out_ready=1 they pop on 3 consecutive cycles.
- Flush with 5 entries pending, same cycle as alloc -> count=0, empty=1, out_valid=0. A later fin matching an old idx leaves count=0.
